register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//  Parametrised multi-read-port integer register file with a per-register busy scoreboard.
//  Sits between decode (reserves destinations, reads operands) and writeback (writes results).
//  Issue logic stalls on rd_busy_o; reserve handshake blocks WAW on an in-flight destination.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH
//  NUM_READ    2   number of independent read ports (1..4)
//  ZERO_REG    1   1: register 0 reads 0, ignores writes and reservations
// PORTS
//  clock_i             in   1                    rising-edge clock
//  reset_i             in   1                    synchronous, active-high reset
//  reg_write_i         in   1                    writeback strobe
//  wr_register_i       in   ADDR_WIDTH           writeback index
//  wr_data_i           in   DATA_WIDTH           writeback data
//  rd_register_i       in   NUM_READ*ADDR_WIDTH  read indices; port k = [k*ADDR_WIDTH +: ADDR_WIDTH]
//  rd_data_o           out  NUM_READ*DATA_WIDTH  read data, packed as above
//  rd_busy_o           out  NUM_READ             1: indexed register has pending result
//  reserve_valid_i     in   1                    request to mark a destination busy
//  reserve_register_i  in   ADDR_WIDTH           destination to reserve
//  reserve_ready_o     out  1                    reservation can be accepted this cycle
//  busy_count_o        out  ADDR_WIDTH+1         number of busy registers
// BEHAVIOUR
//  Reset (reset_i=1 at edge): all registers 0, all busy bits 0, busy_count_o 0; reset wins over
//   every same-cycle write/reserve. After reset: rd_data_o 0, rd_busy_o 0, reserve_ready_o 1.
//  Reads: combinational, zero latency. ZERO_REG=1 and index 0 -> data 0, busy 0.
//  Write: at edge when reg_write_i=1, regs[wr_register_i] <= wr_data_i and busy bit cleared.
//   Write to non-busy register is legal: data updated, busy_count_o unchanged.
//   ZERO_REG=1 and wr_register_i=0: discarded.
//  Reserve handshake: accepted at edge when reserve_valid_i & reserve_ready_o; sets busy bit.
//   reserve_ready_o = ~busy[r] | (reg_write_i & wr_register_i==r), r = reserve_register_i.
//   Reserve of register 0 with ZERO_REG=1: ready=1, accepted, no effect on state or count.
//   Same register written and reserved in one cycle: reserve wins, busy stays 1, count unchanged.
//  busy_count_o: +1 on accepted reserve of a non-busy register, -1 on write clearing a busy bit,
//   net 0 on both (any registers); never wraps (max 2**ADDR_WIDTH, sized ADDR_WIDTH+1).
//  No state machine beyond the busy vector; all updates single-cycle.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: read port whose index equals wr_register_i while reg_write_i=1
//   returns wr_data_i and rd_busy_o=0 same cycle (unless reserved again that cycle: busy=1, data
//   still bypassed). Not defined: returns stored value and stored busy bit; new value next cycle.
//  ZERO_REG=1 index 0 is never bypassed.
// STRUCTURE
//  Shared header register_file_defs.vh: default DATA_WIDTH/ADDR_WIDTH localparams, ZERO_INDEX,
//   packed-port slice macros shared with decode and writeback.
//  Sub-module regfile_scoreboard: busy vector, reserve_ready_o, busy_count_o; top keeps storage,
//   read muxes (generate loop over NUM_READ) and bypass.
// TESTING
//  Reset: write x1=0x55555555, pulse reset_i -> rd x1 = 0, busy_count_o=0, reserve_ready_o=1.
//  Write/read: write x1=0x55555555, x2=0xAAAAAAAA; port0=x2, port1=x1 -> 0xAAAAAAAA, 0x55555555.
//  x0: write x0=0xFFFFFFFF, reserve x0 -> rd x0 = 0, rd_busy_o=0, busy_count_o unchanged.
//  Scoreboard: reserve x3 -> rd_busy=1, count=1; reserve x3 again -> ready=0; write x3=0x12 ->
//   busy=0, count=0, data 0x12.
//  Simultaneous: x4 busy, write x4=0x7 and reserve x4 same cycle -> busy=1, count=1, x4=0x7.
//  Bypass: read x5 while writing x5=0xDEADBEEF -> 0xDEADBEEF with REGFILE_BYPASS_EN, old 0 without.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// Shared defaults and packed-port slice helper for the register file, decode and writeback.
package register_file_sb_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned NUM_READ_DEF   = 2;
  localparam int unsigned ZERO_INDEX     = 0;

  // LSB of port `port` inside a packed multi-port vector of `width`-bit fields
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus of the register file: write, multi-port read and reserve handshake.
interface register_file_sb_if
  import register_file_sb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_READ   = NUM_READ_DEF
) ();

  logic                           reg_write_i;
  logic [ADDR_WIDTH-1:0]          wr_register_i;
  logic [DATA_WIDTH-1:0]          wr_data_i;
  logic [NUM_READ*ADDR_WIDTH-1:0] rd_register_i;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_o;
  logic [NUM_READ-1:0]            rd_busy_o;
  logic                           reserve_valid_i;
  logic [ADDR_WIDTH-1:0]          reserve_register_i;
  logic                           reserve_ready_o;
  logic [ADDR_WIDTH:0]            busy_count_o;

  modport master (
    output reg_write_i, wr_register_i, wr_data_i, rd_register_i,
    output reserve_valid_i, reserve_register_i,
    input  rd_data_o, rd_busy_o, reserve_ready_o, busy_count_o
  );

  modport slave (
    input  reg_write_i, wr_register_i, wr_data_i, rd_register_i,
    input  reserve_valid_i, reserve_register_i,
    output rd_data_o, rd_busy_o, reserve_ready_o, busy_count_o
  );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy vector, reserve handshake readiness and busy-register population count.
module register_file_sb_scoreboard
  import register_file_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         reg_write_i,
  input  logic [ADDR_WIDTH-1:0]        wr_register_i,
  input  logic                         reserve_valid_i,
  input  logic [ADDR_WIDTH-1:0]        reserve_register_i,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy_o,
  output logic                         reserve_ready_c,
  output logic [ADDR_WIDTH:0]          busy_count_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DEPTH-1:0] busy_q, busy_d, busy_cleared_c;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en_c, rsv_en_c, inc_c, dec_c;

  // Write clears first, reserve sets afterwards so a same-register reserve wins
  always_comb begin
    wr_en_c         = reg_write_i &&
                      !((ZERO_REG != 0) && (wr_register_i == ADDR_WIDTH'(ZERO_INDEX)));
    reserve_ready_c = !busy_q[reserve_register_i] ||
                      (reg_write_i && (wr_register_i == reserve_register_i));
    rsv_en_c        = reserve_valid_i && reserve_ready_c &&
                      !((ZERO_REG != 0) && (reserve_register_i == ADDR_WIDTH'(ZERO_INDEX)));

    busy_cleared_c = busy_q;
    if (wr_en_c) begin
      busy_cleared_c[wr_register_i] = 1'b0;
    end

    dec_c = wr_en_c && busy_q[wr_register_i];
    inc_c = rsv_en_c && !busy_cleared_c[reserve_register_i];

    busy_d = busy_cleared_c;
    if (rsv_en_c) begin
      busy_d[reserve_register_i] = 1'b1;
    end

    count_d = count_q + CW'(inc_c) - CW'(dec_c);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with busy scoreboard; storage, read muxes and write bypass.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_READ   = NUM_READ_DEF,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  register_file_sb_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_c;
  logic                  wr_en_c;
  logic                  reserve_ready_c;

  register_file_sb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .reg_write_i        (bus.reg_write_i),
    .wr_register_i      (bus.wr_register_i),
    .reserve_valid_i    (bus.reserve_valid_i),
    .reserve_register_i (bus.reserve_register_i),
    .busy_o             (busy_c),
    .reserve_ready_c    (reserve_ready_c),
    .busy_count_o       (bus.busy_count_o)
  );

  assign bus.reserve_ready_o = reserve_ready_c;

  always_comb begin
    wr_en_c = bus.reg_write_i &&
              !((ZERO_REG != 0) && (bus.wr_register_i == ADDR_WIDTH'(ZERO_INDEX)));
    regs_d  = regs_q;
    if (wr_en_c) begin
      regs_d[bus.wr_register_i] = bus.wr_data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx_c;
    logic [DATA_WIDTH-1:0] data_c;
    logic                  busy_rd_c;

    assign idx_c = bus.rd_register_i[port_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];

    // Register 0 override sits last so it also masks any bypass
    always_comb begin
      data_c    = regs_q[idx_c];
      busy_rd_c = busy_c[idx_c];
`ifdef REGFILE_BYPASS_EN
      if (wr_en_c && (bus.wr_register_i == idx_c)) begin
        data_c    = bus.wr_data_i;
        busy_rd_c = bus.reserve_valid_i && (bus.reserve_register_i == idx_c);
      end
`endif
      if ((ZERO_REG != 0) && (idx_c == ADDR_WIDTH'(ZERO_INDEX))) begin
        data_c    = '0;
        busy_rd_c = 1'b0;
      end
    end

    assign bus.rd_data_o[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = data_c;
    assign bus.rd_busy_o[k] = busy_rd_c;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb (2 read ports, 32x32, ZERO_REG=1).
// Expected bypass results follow REGFILE_BYPASS_EN.
module tb_register_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

  register_file_sb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NR),
    .ZERO_REG   (1)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.reg_write_i        = 1'b0;
    bus.wr_register_i      = '0;
    bus.wr_data_i          = '0;
    bus.reserve_valid_i    = 1'b0;
    bus.reserve_register_i = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    bus.rd_register_i = {p1, p0};
  endtask

  task automatic write_reg(input logic [AW-1:0] r, input logic [DW-1:0] d);
    bus.reg_write_i   = 1'b1;
    bus.wr_register_i = r;
    bus.wr_data_i     = d;
    tick();
    bus.reg_write_i   = 1'b0;
  endtask

  task automatic reserve_reg(input logic [AW-1:0] r);
    bus.reserve_valid_i    = 1'b1;
    bus.reserve_register_i = r;
    tick();
    bus.reserve_valid_i    = 1'b0;
  endtask

  function automatic logic [63:0] rd0();
    return 64'(bus.rd_data_o[31:0]);
  endfunction

  function automatic logic [63:0] rd1();
    return 64'(bus.rd_data_o[63:32]);
  endfunction

  initial begin
    idle();
    set_rd(5'd1, 5'd2);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.reserve_register_i = 5'd1;
    settle();
    check("rst_rd0", rd0(), 64'h0);
    check("rst_busy", 64'(bus.rd_busy_o), 64'h0);
    check("rst_ready", 64'(bus.reserve_ready_o), 64'h1);
    check("rst_count", 64'(bus.busy_count_o), 64'h0);

    // Reset wins over a same-cycle write and clears pending reservations
    write_reg(5'd1, 32'h5555_5555);
    settle();
    check("wr_x1", rd0(), 64'h5555_5555);
    reserve_reg(5'd1);
    settle();
    check("pre_rst_count", 64'(bus.busy_count_o), 64'h1);
    rst = 1'b1;
    bus.reg_write_i   = 1'b1;
    bus.wr_register_i = 5'd2;
    bus.wr_data_i     = 32'h0000_1234;
    tick();
    rst = 1'b0;
    idle();
    bus.reserve_register_i = 5'd1;
    settle();
    check("rst2_x1", rd0(), 64'h0);
    check("rst2_x2", rd1(), 64'h0);
    check("rst2_busy", 64'(bus.rd_busy_o), 64'h0);
    check("rst2_count", 64'(bus.busy_count_o), 64'h0);
    check("rst2_ready", 64'(bus.reserve_ready_o), 64'h1);

    write_reg(5'd1, 32'h5555_5555);
    write_reg(5'd2, 32'hAAAA_AAAA);
    set_rd(5'd2, 5'd1);
    settle();
    check("rd_p0_x2", rd0(), 64'hAAAA_AAAA);
    check("rd_p1_x1", rd1(), 64'h5555_5555);

    // Register 0: writes and reservations have no effect
    write_reg(5'd0, 32'hFFFF_FFFF);
    bus.reserve_valid_i    = 1'b1;
    bus.reserve_register_i = 5'd0;
    settle();
    check("x0_ready", 64'(bus.reserve_ready_o), 64'h1);
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    settle();
    check("x0_data", rd0(), 64'h0);
    check("x0_busy", 64'(bus.rd_busy_o), 64'h0);
    check("x0_count", 64'(bus.busy_count_o), 64'h0);

    reserve_reg(5'd3);
    set_rd(5'd3, 5'd0);
    settle();
    check("x3_busy", 64'(bus.rd_busy_o), 64'h1);
    check("x3_count", 64'(bus.busy_count_o), 64'h1);
    bus.reserve_valid_i    = 1'b1;
    bus.reserve_register_i = 5'd3;
    settle();
    check("x3_ready_waw", 64'(bus.reserve_ready_o), 64'h0);
    tick();
    idle();
    settle();
    check("x3_count_held", 64'(bus.busy_count_o), 64'h1);
    write_reg(5'd3, 32'h0000_0012);
    settle();
    check("x3_busy_clr", 64'(bus.rd_busy_o), 64'h0);
    check("x3_count_clr", 64'(bus.busy_count_o), 64'h0);
    check("x3_data", rd0(), 64'h12);

    // Same register written and reserved: reserve wins, count unchanged
    reserve_reg(5'd4);
    set_rd(5'd4, 5'd0);
    bus.reg_write_i        = 1'b1;
    bus.wr_register_i      = 5'd4;
    bus.wr_data_i          = 32'h0000_0007;
    bus.reserve_valid_i    = 1'b1;
    bus.reserve_register_i = 5'd4;
    settle();
    check("x4_ready_wr", 64'(bus.reserve_ready_o), 64'h1);
    tick();
    idle();
    settle();
    check("x4_busy", 64'(bus.rd_busy_o), 64'h1);
    check("x4_count", 64'(bus.busy_count_o), 64'h1);
    check("x4_data", rd0(), 64'h7);

    // Clear x4 while reserving x6: net zero on the count
    set_rd(5'd4, 5'd6);
    bus.reg_write_i        = 1'b1;
    bus.wr_register_i      = 5'd4;
    bus.wr_data_i          = 32'h0000_0008;
    bus.reserve_valid_i    = 1'b1;
    bus.reserve_register_i = 5'd6;
    tick();
    idle();
    settle();
    check("x4x6_busy", 64'(bus.rd_busy_o), 64'h2);
    check("x4x6_count", 64'(bus.busy_count_o), 64'h1);
    check("x4x6_data", rd0(), 64'h8);

    write_reg(5'd1, 32'h0BAD_F00D);
    set_rd(5'd1, 5'd6);
    settle();
    check("nonbusy_wr_count", 64'(bus.busy_count_o), 64'h1);
    check("nonbusy_wr_data", rd0(), 64'h0BAD_F00D);

    // Same-cycle read of the register being written
    set_rd(5'd5, 5'd0);
    bus.reg_write_i   = 1'b1;
    bus.wr_register_i = 5'd5;
    bus.wr_data_i     = 32'hDEAD_BEEF;
    settle();
    check("byp_x5_data", rd0(), BYP ? 64'hDEAD_BEEF : 64'h0);
    check("byp_x5_busy", 64'(bus.rd_busy_o), 64'h0);
    tick();
    set_rd(5'd0, 5'd5);
    bus.wr_register_i = 5'd0;
    bus.wr_data_i     = 32'h1111_1111;
    settle();
    check("byp_x0_never", rd0(), 64'h0);
    check("x5_stored", rd1(), 64'hDEAD_BEEF);
    tick();
    idle();

    set_rd(5'd7, 5'd0);
    bus.reg_write_i        = 1'b1;
    bus.wr_register_i      = 5'd7;
    bus.wr_data_i          = 32'h0000_0099;
    bus.reserve_valid_i    = 1'b1;
    bus.reserve_register_i = 5'd7;
    settle();
    check("byp_x7_data", rd0(), BYP ? 64'h99 : 64'h0);
    check("byp_x7_busy", 64'(bus.rd_busy_o), BYP ? 64'h1 : 64'h0);
    tick();
    idle();
    settle();
    check("x7_data", rd0(), 64'h99);
    check("x7_busy", 64'(bus.rd_busy_o), 64'h1);
    check("x7_count", 64'(bus.busy_count_o), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
